// File: rtl/fnd_pkg.sv
// Shared constants and types for the 4-digit FND display controller.
//   Segment patterns are active-low, bit order {dp,g,f,e,d,c,b,a}.
//   Digit enables are active-low, bit0 = rightmost digit.
package fnd_pkg;

  localparam int unsigned COM_W  = 4;
  localparam int unsigned SEG_W  = 8;
  localparam int unsigned LOW_W  = 7;
  localparam int unsigned HIGH_W = 6;
  localparam int unsigned BCD_W  = 4;
  localparam int unsigned SEL_W  = 2;

  localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
  localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
  localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
  localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
  localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
  localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
  localparam logic [SEG_W-1:0] SEG_DASH  = 8'hBF;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;
  localparam logic [SEG_W-1:0] DP_MASK   = 8'h7F;

  localparam logic [COM_W-1:0] COM_OFF = 4'hF;

  // Digit slot currently being driven; DIG_0 is the rightmost digit.
  typedef enum logic [SEL_W-1:0] {
    DIG_0 = 2'd0,
    DIG_1 = 2'd1,
    DIG_2 = 2'd2,
    DIG_3 = 2'd3
  } digit_sel_e;

  // Registered display drive: digit enables and segment pattern move together.
  typedef struct packed {
    logic [COM_W-1:0] com;
    logic [SEG_W-1:0] data;
  } fnd_drive_t;

  // BCD to active-low segment pattern; non-decimal codes stay dark.
  function automatic logic [SEG_W-1:0] seg_of(input logic [BCD_W-1:0] bcd);
    logic [SEG_W-1:0] seg;
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/fnd_if.sv
// Bundle between the stopwatch datapath and the FND controller.
//   option     : 0 = sec:msec, 1 = hour:min
//   low_digit  : right-hand value, 0..99 valid
//   high_digit : left-hand value, 0..59 valid
//   fnd_com    : active-low digit enables
//   fnd_data   : active-low segments {dp,g,f,e,d,c,b,a}
interface fnd_if;
  import fnd_pkg::*;

  logic              option;
  logic [LOW_W-1:0]  low_digit;
  logic [HIGH_W-1:0] high_digit;
  logic [COM_W-1:0]  fnd_com;
  logic [SEG_W-1:0]  fnd_data;

  // Datapath side: supplies the values, observes the pins.
  modport master (
    output option, low_digit, high_digit,
    input  fnd_com, fnd_data
  );

  // Controller side.
  modport slave (
    input  option, low_digit, high_digit,
    output fnd_com, fnd_data
  );

endinterface

// File: rtl/fnd_seg_decoder.sv
// Combinational segment decoder for one FND digit.
//   bcd     : decimal digit 0..9
//   dp_en   : light the decimal point (clears bit7)
//   dash_en : show a dash instead of the digit (dash wins over dp)
//   seg_c   : active-low pattern {dp,g,f,e,d,c,b,a}
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             dp_en,
  input  logic             dash_en,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = seg_of(bcd);
    if (dash_en) begin
      seg_c = SEG_DASH;
    end else if (dp_en) begin
      seg_c = seg_c & DP_MASK;
    end
  end

endmodule

// File: rtl/fnd_controller.sv
// Time-multiplexed 4-digit common-anode FND driver for the stopwatch.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : fnd_if.slave -- option, low_digit, high_digit in; fnd_com, fnd_data out
// Digits right to left: low%10, low/10, high%10, high/10. The dp on digit 2
// separates the two fields and blinks from the msec value in sec:msec mode.
module fnd_controller
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_COUNT    = 100_000,
  parameter int unsigned DOT_THRESHOLD = 50
) (
  input  logic  clk,
  input  logic  rst,
  fnd_if.slave  bus
);

  localparam int unsigned CNT_W = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_COUNT - 1);

  logic [CNT_W-1:0] scan_cnt;
  logic             scan_tick;
  digit_sel_e       digit_sel;
  fnd_drive_t       drive_q;
  fnd_drive_t       drive_nxt_c;

  logic             scan_last_c;
  logic [BCD_W-1:0] low_ones_c;
  logic [BCD_W-1:0] low_tens_c;
  logic [BCD_W-1:0] high_ones_c;
  logic [BCD_W-1:0] high_tens_c;
  logic             low_bad_c;
  logic             high_bad_c;
  logic             dot_on_c;
  logic [BCD_W-1:0] bcd_c;
  logic             dp_en_c;
  logic             dash_en_c;
  logic [SEG_W-1:0] seg_c;

  assign scan_last_c = (scan_cnt == CNT_LAST);

  // Field split and range flags; out-of-range fields are dashed, never clamped.
  always_comb begin
    low_ones_c  = BCD_W'(bus.low_digit % LOW_W'(10));
    low_tens_c  = BCD_W'(bus.low_digit / LOW_W'(10));
    high_ones_c = BCD_W'(bus.high_digit % HIGH_W'(10));
    high_tens_c = BCD_W'(bus.high_digit / HIGH_W'(10));
    low_bad_c   = (bus.low_digit > LOW_W'(99));
    high_bad_c  = (bus.high_digit > HIGH_W'(59));
    dot_on_c    = bus.option || (32'(bus.low_digit) < DOT_THRESHOLD);
  end

  // Per-slot digit selection and matching active-low enable.
  always_comb begin
    bcd_c           = '0;
    dp_en_c         = 1'b0;
    dash_en_c       = 1'b0;
    drive_nxt_c.com = COM_OFF;
    case (digit_sel)
      DIG_0: begin
        bcd_c           = low_ones_c;
        dash_en_c       = low_bad_c;
        drive_nxt_c.com = 4'b1110;
      end
      DIG_1: begin
        bcd_c           = low_tens_c;
        dash_en_c       = low_bad_c;
        drive_nxt_c.com = 4'b1101;
      end
      DIG_2: begin
        bcd_c           = high_ones_c;
        dash_en_c       = high_bad_c;
        dp_en_c         = dot_on_c;
        drive_nxt_c.com = 4'b1011;
      end
      DIG_3: begin
        bcd_c           = high_tens_c;
        dash_en_c       = high_bad_c;
        drive_nxt_c.com = 4'b0111;
      end
      default: begin
        drive_nxt_c.com = COM_OFF;
      end
    endcase
    drive_nxt_c.data = seg_c;
  end

  fnd_seg_decoder u_seg_decoder (
    .bcd     (bcd_c),
    .dp_en   (dp_en_c),
    .dash_en (dash_en_c),
    .seg_c   (seg_c)
  );

  // Scan timing and output registers. scan_tick is registered, so digit_sel
  // advances one cycle after the count wraps; since the outputs already show
  // digit 0 from the first edge out of reset, that first slot is one cycle
  // longer than the steady-state slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      scan_tick <= 1'b0;
      digit_sel <= DIG_0;
      drive_q   <= '{com: COM_OFF, data: SEG_BLANK};
    end else begin
      scan_cnt  <= scan_last_c ? '0 : scan_cnt + CNT_W'(1);
      scan_tick <= scan_last_c;
      if (scan_tick) begin
        digit_sel <= digit_sel_e'(SEL_W'(digit_sel) + SEL_W'(1));
      end
      drive_q   <= drive_nxt_c;
    end
  end

  assign bus.fnd_com  = drive_q.com;
  assign bus.fnd_data = drive_q.data;

endmodule

// File: tb/tb_fnd_controller.sv
// Scoreboard bench for fnd_controller with SCAN_COUNT=4. A driver applies
// directed and random inputs at the falling edge and queues the expected pin
// state for the next rising edge; a monitor pops and compares every cycle.
module tb_fnd_controller;

  localparam int unsigned SCAN = 4;
  localparam int unsigned DOT  = 50;

  typedef struct {
    logic [3:0] com;
    logic [7:0] data;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  fnd_if bus ();

  fnd_controller #(
    .SCAN_COUNT    (SCAN),
    .DOT_THRESHOLD (DOT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc_out     = 0;   // edges since reset release
  int         model_sel   = 0;   // digit expected on the pins at the queued edge
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Reference: slot position from elapsed cycles, digit from decimal arithmetic.
  task automatic push_expect(input string tag);
    exp_t       e;
    int         lo;
    int         hi;
    int         v;
    bit         bad;
    logic [3:0] one;
    e.tag = tag;
    lo    = int'(bus.low_digit);
    hi    = int'(bus.high_digit);
    one   = 4'b0001;
    if (rst) begin
      cyc_out   = 0;
      model_sel = 0;
      e.com     = 4'hF;
      e.data    = 8'hFF;
    end else begin
      cyc_out++;
      if (cyc_out <= int'(SCAN) + 1) model_sel = 0;
      else model_sel = ((cyc_out - int'(SCAN) - 2) / int'(SCAN) + 1) % 4;
      case (model_sel)
        0: begin v = lo % 10;  bad = (lo > 99); end
        1: begin v = lo / 10;  bad = (lo > 99); end
        2: begin v = hi % 10;  bad = (hi > 59); end
        default: begin v = hi / 10; bad = (hi > 59); end
      endcase
      e.com  = ~(one << model_sel);
      e.data = bad ? 8'hBF : seg_tab[v];
      if (model_sel == 2 && !bad && (bus.option || lo < int'(DOT)))
        e.data = e.data & 8'h7F;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input int nc, input bit r, input bit opt,
                       input int lo, input int hi, input string tag);
    repeat (nc) begin
      @(negedge clk);
      rst            = r;
      bus.option     = opt;
      bus.low_digit  = 7'(lo);
      bus.high_digit = 6'(hi);
      push_expect(tag);
    end
  endtask

  // Monitor: one comparison per rising edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL underflow: output at %0t had no queued expectation", $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.fnd_com !== e.com || bus.fnd_data !== e.data) begin
          miscompares++;
          $display("FAIL %s @%0t: com=%b data=%h, expected com=%b data=%h",
                   e.tag, $time, bus.fnd_com, bus.fnd_data, e.com, e.data);
        end
      end
    end
  end

  initial begin
    int guard;
    rst            = 1'b1;
    bus.option     = 1'b0;
    bus.low_digit  = '0;
    bus.high_digit = '0;
    push_expect("reset");

    drive(3, 1'b1, 1'b0, 0, 0, "reset");
    drive(20, 1'b0, 1'b1, 37, 12, "scan_order");
    drive(16, 1'b0, 1'b0, 49, 5, "dot_on_49");
    drive(16, 1'b0, 1'b0, 50, 5, "dot_off_50");
    drive(16, 1'b0, 1'b1, 100, 60, "range_opt1");
    drive(16, 1'b0, 1'b0, 100, 60, "range_opt0");
    drive(16, 1'b0, 1'b0, 0, 0, "zero_opt0");
    drive(16, 1'b0, 1'b1, 0, 0, "zero_opt1");
    drive(16, 1'b0, 1'b0, 99, 59, "max_opt0");
    drive(16, 1'b0, 1'b1, 99, 59, "max_opt1");

    // Reset while digit 2 is on the pins, then watch a clean restart.
    guard = 0;
    while (model_sel != 2 && guard < 50) begin
      drive(1, 1'b0, 1'b1, 37, 12, "seek_digit2");
      guard++;
    end
    if (model_sel != 2) begin
      miscompares++;
      $display("FAIL seek_digit2: model never reached digit 2 within %0d cycles", guard);
    end
    drive(1, 1'b1, 1'b1, 37, 12, "mid_reset");
    drive(24, 1'b0, 1'b1, 37, 12, "after_mid_reset");

    // Random inputs, mostly in range, with occasional resets and mode flips.
    for (int i = 0; i < 400; i++) begin
      int lo;
      int hi;
      bit r;
      r  = ($urandom_range(0, 59) == 0);
      lo = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 99));
      hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 59));
      drive(int'($urandom_range(1, 3)), r, 1'($urandom_range(0, 1)), lo, hi, "random");
    end

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
